// File: rtl/sm_pkg.sv
// Shared definitions for the sm_param stack machine: opcode and status
// encodings plus the controller state type.
package sm_pkg;

    // Opcodes carried in the top three instruction bits.
    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DUP  = 3'b100;
    localparam logic [2:0] OP_SWAP = 3'b101;
    localparam logic [2:0] OP_POP  = 3'b110;
    localparam logic [2:0] OP_END  = 3'b111;

    // Status reported alongside every executed instruction.
    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_UNDER = 3'd1;
    localparam logic [2:0] ERR_OVER  = 3'd2;
    localparam logic [2:0] ERR_ARITH = 3'd3;

    // Controller: executing the program, or finished until the next reset.
    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/sm_alu.sv
// Combinational arithmetic unit of the stack machine: a op b for ADD/SUB/MUL
// with signed-overflow detection. The stored value on overflow is the
// truncated result by default, or a saturated bound when SM_SAT_EN is defined.
module sm_alu
    import sm_pkg::*;
#(
    parameter int DATA_W = 20
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic        [2:0]        op,
    output logic signed [DATA_W-1:0] result,
    output logic                     ovf
);

`ifdef SM_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    logic signed [DATA_W:0]     sum_w;    // one guard bit holds the true add/sub result
    logic signed [2*DATA_W-1:0] prod_w;   // full-width product
    logic        [DATA_W:0]     prod_hi;  // bits that must all agree for the product to fit
    logic signed [DATA_W-1:0]   wrapped;

    // Compute the exact result, its truncation and whether it fits in DATA_W bits.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path leaves one unassigned and no latch is inferred.
        sum_w   = '0;
        prod_w  = '0;
        prod_hi = '0;
        wrapped = '0;
        ovf     = 1'b0;
        case (op)
            OP_ADD: begin
                sum_w   = (DATA_W+1)'(a) + (DATA_W+1)'(b);
                wrapped = sum_w[DATA_W-1:0];
                ovf     = sum_w[DATA_W] ^ sum_w[DATA_W-1];
            end
            OP_SUB: begin
                sum_w   = (DATA_W+1)'(a) - (DATA_W+1)'(b);
                wrapped = sum_w[DATA_W-1:0];
                ovf     = sum_w[DATA_W] ^ sum_w[DATA_W-1];
            end
            OP_MUL: begin
                prod_w  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
                prod_hi = prod_w[2*DATA_W-1:DATA_W-1];
                wrapped = prod_w[DATA_W-1:0];
                ovf     = !((prod_hi == '0) || (prod_hi == '1));
            end
            default: ;
        endcase

`ifdef SM_SAT_EN
        // Clamp toward the sign of the exact result.
        result = wrapped;
        if (ovf) begin
            if ((op == OP_MUL) ? prod_w[2*DATA_W-1] : sum_w[DATA_W])
                result = SAT_MIN;
            else
                result = SAT_MAX;
        end
`else
        result = wrapped;
`endif
    end

endmodule

// File: rtl/sm_param.sv
// sm_param: parametrised stack machine. Fetches one instruction per cycle at
// `pc`, executes it against an internal LIFO of DEPTH signed words and reports
// result/status one cycle later with a d_valid strobe. Saturating arithmetic
// overflow is selected by defining SM_SAT_EN (handled inside sm_alu).
module sm_param
    import sm_pkg::*;
#(
    parameter int IMM_W  = 10,
    parameter int DATA_W = 20,
    parameter int DEPTH  = 8,
    parameter int PC_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IMM_W+2:0]         instr,
    output logic [PC_W-1:0]          pc,
    output logic                     d_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic [2:0]               err_code,
    output logic                     fin
);

    localparam int SP_W = $clog2(DEPTH);

    // The stack pointer counts entries 0..DEPTH, so it is one bit wider than an index.
    localparam logic [SP_W:0]   SP_ZERO = '0;
    localparam logic [SP_W:0]   SP_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W:0]   SP_TWO  = (SP_W+1)'(2);
    localparam logic [SP_W:0]   SP_FULL = (SP_W+1)'(DEPTH);
    localparam logic [SP_W-1:0] IDX_ONE = SP_W'(1);
    localparam logic [SP_W-1:0] IDX_TWO = SP_W'(2);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
    localparam logic [PC_W-1:0] PC_LAST = '1;

    // Architectural state.
    state_t                    state_q, state_d;
    logic [PC_W-1:0]           pc_q, pc_d;
    logic [SP_W:0]             sp_q, sp_d;
    logic signed [DATA_W-1:0]  stack_q [DEPTH];

    // Registered report.
    logic                      d_valid_q, d_valid_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;
    logic [2:0]                err_q, err_d;

    // Two stack write ports: SWAP updates two entries in one cycle.
    logic                      wr0_en, wr1_en;
    logic [SP_W-1:0]           wr0_idx, wr1_idx;
    logic signed [DATA_W-1:0]  wr0_data, wr1_data;

    // Instruction decode.
    logic [2:0]                opcode;
    logic signed [IMM_W-1:0]   imm;
    logic signed [DATA_W-1:0]  imm_ext;

    assign opcode  = instr[IMM_W+2:IMM_W];
    assign imm     = instr[IMM_W-1:0];
    assign imm_ext = DATA_W'(imm);  // signed cast sign-extends

    // Entry addressing relative to the stack pointer; only read when occupied.
    logic [SP_W-1:0]           push_idx, top_idx, nxt_idx;
    logic signed [DATA_W-1:0]  top_val, nxt_val;

    assign push_idx = sp_q[SP_W-1:0];
    assign top_idx  = sp_q[SP_W-1:0] - IDX_ONE;
    assign nxt_idx  = sp_q[SP_W-1:0] - IDX_TWO;
    assign top_val  = stack_q[top_idx];
    assign nxt_val  = stack_q[nxt_idx];

    // Arithmetic on next (a) and top (b).
    logic signed [DATA_W-1:0]  alu_res;
    logic                      alu_ovf;

    sm_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (nxt_val),
        .b      (top_val),
        .op     (opcode),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    // Next-state, stack-update and report logic for one instruction.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        d_valid_d  = 1'b0;
        out_data_d = '0;
        err_d      = ERR_OK;
        wr0_en     = 1'b0;
        wr0_idx    = push_idx;
        wr0_data   = '0;
        wr1_en     = 1'b0;
        wr1_idx    = nxt_idx;
        wr1_data   = '0;

        if (state_q == S_RUN) begin
            d_valid_d = 1'b1;
            // The last address finishes the program instead of wrapping to 0.
            if (pc_q == PC_LAST)
                state_d = S_DONE;
            else
                pc_d = pc_q + PC_ONE;

            case (opcode)
                OP_PUSH: begin
                    if (sp_q == SP_FULL) begin
                        err_d = ERR_OVER;
                    end else begin
                        wr0_en     = 1'b1;
                        wr0_idx    = push_idx;
                        wr0_data   = imm_ext;
                        sp_d       = sp_q + SP_ONE;
                        out_data_d = imm_ext;
                    end
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (sp_q < SP_TWO) begin
                        err_d = ERR_UNDER;
                    end else begin
                        // Result replaces 'next'; 'top' is dropped.
                        wr0_en     = 1'b1;
                        wr0_idx    = nxt_idx;
                        wr0_data   = alu_res;
                        sp_d       = sp_q - SP_ONE;
                        out_data_d = alu_res;
                        err_d      = alu_ovf ? ERR_ARITH : ERR_OK;
                    end
                end
                OP_DUP: begin
                    if (sp_q == SP_ZERO) begin
                        err_d = ERR_UNDER;
                    end else if (sp_q == SP_FULL) begin
                        err_d = ERR_OVER;
                    end else begin
                        wr0_en     = 1'b1;
                        wr0_idx    = push_idx;
                        wr0_data   = top_val;
                        sp_d       = sp_q + SP_ONE;
                        out_data_d = top_val;
                    end
                end
                OP_SWAP: begin
                    if (sp_q < SP_TWO) begin
                        err_d = ERR_UNDER;
                    end else begin
                        wr0_en     = 1'b1;
                        wr0_idx    = top_idx;
                        wr0_data   = nxt_val;
                        wr1_en     = 1'b1;
                        wr1_idx    = nxt_idx;
                        wr1_data   = top_val;
                        out_data_d = nxt_val;
                    end
                end
                OP_POP: begin
                    if (sp_q == SP_ZERO) begin
                        err_d = ERR_UNDER;
                    end else begin
                        sp_d       = sp_q - SP_ONE;
                        out_data_d = top_val;
                    end
                end
                OP_END: begin
                    state_d    = S_DONE;
                    out_data_d = (sp_q == SP_ZERO) ? '0 : top_val;
                end
                default: ;
            endcase
        end
    end

    // Controller state, program counter, stack pointer and report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= '0;
            sp_q       <= '0;
            d_valid_q  <= 1'b0;
            out_data_q <= '0;
            err_q      <= ERR_OK;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            d_valid_q  <= d_valid_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    // Stack storage writes.
    // NOTE: the entries are not reset; the stack pointer alone decides which are live.
    always_ff @(posedge clk) begin
        if (wr0_en)
            stack_q[wr0_idx] <= wr0_data;
        if (wr1_en)
            stack_q[wr1_idx] <= wr1_data;
    end

    assign pc       = pc_q;
    assign d_valid  = d_valid_q;
    assign out_data = out_data_q;
    assign err_code = err_q;
    assign fin      = (state_q == S_DONE);

endmodule

// File: tb/tb_sm_param.sv
// Self-checking bench for sm_param (IMM_W=10, DATA_W=20, DEPTH=8, PC_W=10).
// Directed vector tables, hand sequences for END / reset, and random programs
// checked against a queue-based reference model. Honours SM_SAT_EN.
module tb_sm_param;
    import sm_pkg::*;

    localparam int IMM_W  = 10;
    localparam int DATA_W = 20;
    localparam int DEPTH  = 8;
    localparam int PC_W   = 10;
    localparam int IW     = IMM_W + 3;
    localparam int PC_MAX = (1 << PC_W) - 1;
    localparam longint VMAX = (longint'(1) << (DATA_W-1)) - 1;
    localparam longint VMIN = -(longint'(1) << (DATA_W-1));

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [IW-1:0]            instr;
    logic [PC_W-1:0]          pc;
    logic                     d_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [2:0]               err_code;
    logic                     fin;

    logic [IW-1:0] imem [0:PC_MAX];
    assign instr = imem[pc];

    always #5 clk = ~clk;

    sm_param #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PC_W   (PC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .pc       (pc),
        .d_valid  (d_valid),
        .out_data (out_data),
        .err_code (err_code),
        .fin      (fin)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input int imm);
        return {op, imm[IMM_W-1:0]};
    endfunction

    // ---------------- reference model ----------------
    longint mstk[$];
    int     mpc;
    bit     mdone;

    function automatic longint wrapv(input longint x);
        longint m = longint'(1) << DATA_W;
        longint r = x % m;
        if (r < 0) r += m;
        if (r > VMAX) r -= m;
        return r;
    endfunction

    task automatic model_step(output bit v, output longint d, output int e);
        logic [IW-1:0] ins;
        logic [2:0]    op;
        longint        imm, a, b, t;
        v = 1'b0; d = 0; e = 0;
        if (mdone) return;
        ins = imem[mpc];
        op  = ins[IW-1:IMM_W];
        imm = longint'($signed(ins[IMM_W-1:0]));
        v   = 1'b1;
        case (op)
            OP_PUSH: if (mstk.size() == DEPTH) e = 2; else begin mstk.push_back(imm); d = imm; end
            OP_ADD, OP_SUB, OP_MUL: begin
                if (mstk.size() < 2) e = 1;
                else begin
                    b = mstk.pop_back();
                    a = mstk.pop_back();
                    t = (op == OP_ADD) ? a + b : (op == OP_SUB) ? a - b : a * b;
                    if (t > VMAX || t < VMIN) begin
                        e = 3;
`ifdef SM_SAT_EN
                        t = (t > 0) ? VMAX : VMIN;
`else
                        t = wrapv(t);
`endif
                    end
                    mstk.push_back(t);
                    d = t;
                end
            end
            OP_DUP: begin
                if (mstk.size() == 0) e = 1;
                else if (mstk.size() == DEPTH) e = 2;
                else begin d = mstk[$]; mstk.push_back(d); end
            end
            OP_SWAP: begin
                if (mstk.size() < 2) e = 1;
                else begin
                    a = mstk.pop_back();
                    b = mstk.pop_back();
                    mstk.push_back(a);
                    mstk.push_back(b);
                    d = b;
                end
            end
            OP_POP: if (mstk.size() == 0) e = 1; else d = mstk.pop_back();
            default: d = (mstk.size() == 0) ? 0 : mstk[$];  // END
        endcase
        if (mpc == PC_MAX) mdone = 1'b1; else mpc++;
        if (op == OP_END) mdone = 1'b1;
    endtask

    task automatic model_cycle(input string tag);
        bit v; longint d; int e;
        @(posedge clk);
        model_step(v, d, e);
        #1;
        check({tag, " d_valid"}, d_valid, v);
        if (v) begin
            check({tag, " out_data"}, out_data, d);
            check({tag, " err_code"}, err_code, e);
        end
        check({tag, " fin"}, fin, mdone);
        check({tag, " pc"}, pc, mpc);
    endtask

    // ---------------- reset helpers ----------------
    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i <= PC_MAX; i++) imem[i] = mk(OP_END, 0);
    endtask

    task automatic release_reset();
        mstk.delete();
        mpc   = 0;
        mdone = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [IW-1:0] rand_ins(input bit allow_end);
        int r = $urandom_range(0, 99);
        int imm = $urandom_range(0, 1023);
        logic [2:0] op;
        if      (r < 35) op = OP_PUSH;
        else if (r < 45) op = OP_ADD;
        else if (r < 55) op = OP_SUB;
        else if (r < 63) op = OP_MUL;
        else if (r < 73) op = OP_DUP;
        else if (r < 81) op = OP_SWAP;
        else if (r < 98 || !allow_end) op = OP_POP;
        else op = OP_END;
        return mk(op, imm);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [IW-1:0] ins;
        longint        exp_data;
        int            exp_err;
    } vec_t;

    vec_t vecs[$];
    int   grp_lo[4];
    int   grp_hi[4];

    function automatic void add_vec(input logic [2:0] op, input int imm,
                                    input longint d, input int e);
        vec_t v;
        v.ins = mk(op, imm);
        v.exp_data = d;
        v.exp_err = e;
        vecs.push_back(v);
    endfunction

    initial begin
        // Group 0: arithmetic and underflow, stack keeps -2.
        grp_lo[0] = vecs.size();
        add_vec(OP_PUSH, 3, 3, 0);
        add_vec(OP_PUSH, 5, 5, 0);
        add_vec(OP_SUB, 0, -2, 0);
        add_vec(OP_MUL, 0, 0, 1);
        add_vec(OP_DUP, 0, -2, 0);
        grp_hi[0] = vecs.size() - 1;
        // Group 1: fill, overflow on the ninth push, then pop.
        grp_lo[1] = vecs.size();
        for (int i = 0; i < 8; i++) add_vec(OP_PUSH, 1, 1, 0);
        add_vec(OP_PUSH, 1, 0, 2);
        add_vec(OP_POP, 0, 1, 0);
        grp_hi[1] = vecs.size() - 1;
        // Group 2: multiplication growth into arithmetic overflow.
        grp_lo[2] = vecs.size();
        add_vec(OP_PUSH, 511, 511, 0);
        add_vec(OP_DUP, 0, 511, 0);
        add_vec(OP_MUL, 0, 261121, 0);
        add_vec(OP_DUP, 0, 261121, 0);
`ifdef SM_SAT_EN
        add_vec(OP_MUL, 0, 524287, 3);
`else
        add_vec(OP_MUL, 0, 522241, 3);   // 261121^2 mod 2^20
`endif
        grp_hi[2] = vecs.size() - 1;
        // Group 3: negative immediates, SWAP, SUB and SWAP underflow.
        grp_lo[3] = vecs.size();
        add_vec(OP_PUSH, -512, -512, 0);
        add_vec(OP_PUSH, 7, 7, 0);
        add_vec(OP_SWAP, 0, -512, 0);
        add_vec(OP_SUB, 0, 519, 0);
        add_vec(OP_SWAP, 0, 0, 1);
        grp_hi[3] = vecs.size() - 1;

        // Reset values.
        for (int i = 0; i <= PC_MAX; i++) imem[i] = mk(OP_END, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", pc, 0);
        check("reset d_valid", d_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset err_code", err_code, 0);
        check("reset fin", fin, 0);

        // Table-driven groups.
        for (int g = 0; g < 4; g++) begin
            hold_reset();
            for (int i = grp_lo[g]; i <= grp_hi[g]; i++) imem[i - grp_lo[g]] = vecs[i].ins;
            release_reset();
            for (int i = grp_lo[g]; i <= grp_hi[g]; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("vec%0d d_valid", i), d_valid, 1);
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
                check($sformatf("vec%0d err_code", i), err_code, vecs[i].exp_err);
            end
        end

        // END: final report, then fin held, pc frozen, no further strobes.
        hold_reset();
        imem[0] = mk(OP_PUSH, 4);
        imem[1] = mk(OP_END, 0);
        release_reset();
        @(posedge clk); #1;
        check("end push d_valid", d_valid, 1);
        check("end push out_data", out_data, 4);
        check("end push fin", fin, 0);
        @(posedge clk); #1;
        check("end report d_valid", d_valid, 1);
        check("end report out_data", out_data, 4);
        check("end report err_code", err_code, 0);
        check("end report fin", fin, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("done d_valid", d_valid, 0);
            check("done fin", fin, 1);
            check("done pc", pc, 2);
        end

        // Asynchronous reset mid-program after three pushes.
        hold_reset();
        for (int i = 0; i < 3; i++) imem[i] = mk(OP_PUSH, i + 1);
        release_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst pc", pc, 0);
        check("midrst d_valid", d_valid, 0);
        check("midrst out_data", out_data, 0);
        check("midrst err_code", err_code, 0);
        check("midrst fin", fin, 0);
        imem[0] = mk(OP_POP, 0);
        release_reset();
        @(posedge clk); #1;
        check("midrst pop d_valid", d_valid, 1);
        check("midrst pop out_data", out_data, 0);
        check("midrst pop err_code", err_code, 1);

        // Random full-length program without END: runs into the pc boundary.
        hold_reset();
        for (int i = 0; i <= PC_MAX; i++) imem[i] = rand_ins(1'b0);
        release_reset();
        for (int c = 0; c < PC_MAX + 8; c++) model_cycle("rand_bound");

        // Random programs that may contain END.
        for (int p = 0; p < 3; p++) begin
            hold_reset();
            for (int i = 0; i <= PC_MAX; i++) imem[i] = rand_ins(1'b1);
            release_reset();
            for (int c = 0; c < 150; c++) model_cycle("rand_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_param.md
Name: sm_param

Overview:
- Parametrised next-generation stack machine: fetches one instruction per cycle by address `pc`.
- Executes push, arithmetic and stack-manipulation ops on an internal LIFO of DEPTH signed words.
- Reports every executed instruction's result and error code through a one-cycle `d_valid` strobe.
- Sits between an instruction memory (driven from `pc`) and a result checker/consumer.
- Adds DUP/SWAP/POP/END, arithmetic-overflow detection and width/depth generality.

Parameters:
- IMM_W, 10, push immediate width; instruction width = IMM_W+3.
- DATA_W, 20, signed stack/result word width (DATA_W >= IMM_W).
- DEPTH, 8, stack entries (power of two, >= 2).
- PC_W, 10, program counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  IMM_W+3  instruction {opcode[IMM_W+2:IMM_W], imm[IMM_W-1:0]} for the current `pc`.
- pc  output  PC_W  address of the instruction sampled at the next rising edge.
- d_valid  output  1  `out_data`/`err_code` valid this cycle.
- out_data  output  DATA_W  signed result.
- err_code  output  3  status of the reported instruction.
- fin  output  1  program finished; held high.

Behaviour:
- Opcodes:
  - PUSH=000: push sign-extended imm.
  - ADD=001, SUB=010, MUL=011: pop b (top), pop a (next), push a op b.
  - DUP=100: push a copy of top.
  - SWAP=101: exchange top and next.
  - POP=110: remove top.
  - END=111: finish.
- Error codes:
  - 0: OK.
  - 1: underflow. Fewer than 2 entries for ADD/SUB/MUL/SWAP; 0 entries for DUP/POP.
  - 2: overflow. Stack full on PUSH/DUP.
  - 3: arithmetic overflow. The true result is outside the signed DATA_W range.
- Errors 1 and 2: stack and stack pointer unchanged; `out_data` = 0.
- Error 3: stack is updated with the wrapped (truncated) result; `out_data` = that stored value.
- Precedence: 1 over 2 over 3.
- MUL: full 2*DATA_W signed product, overflow if the upper DATA_W+1 bits are not all equal.
- `out_data` per op:
  - PUSH: the pushed value.
  - Arithmetic: the result.
  - DUP: the duplicated value.
  - SWAP: the new top.
  - POP: the removed value.
- FSM states: RUN, DONE.
- Reset:
  - State = RUN; `pc` = 0; stack pointer = 0.
  - `d_valid` = 0, `out_data` = 0, `err_code` = 0, `fin` = 0.
  - Stack contents are don't-care.
- RUN, each rising edge:
  - Sample `instr` at the current `pc`, execute it, and set `pc <= pc+1`.
  - Register the results: `d_valid` = 1, `out_data` and `err_code` appear in the following cycle.
  - Throughput is 1 instruction/cycle with latency 1.
- END in RUN:
  - Next cycle: `d_valid` = 1, `err_code` = 0, `out_data` = top of stack (0 if empty).
  - State goes to DONE; `pc` holds.
- `pc` boundary: when the instruction at `pc` = 2^PC_W-1 executes, the state goes to DONE instead of wrapping. `pc` holds at all ones.
- DONE:
  - `fin` = 1 from the first DONE cycle onward.
  - `d_valid` = 0 after the final report cycle.
  - `instr` ignored; state persists until reset.
- Reset asserted mid-program: all state is cleared immediately (asynchronously); execution restarts at `pc` 0 after deassertion.
- `instr` containing X/Z while in RUN is a bench error; no RTL handling is required.

Optional Feature:
- SM_SAT_EN defined: on error 3, the stored and reported value saturates to +2^(DATA_W-1)-1 or -2^(DATA_W-1) by the sign of the true result.
- SM_SAT_EN undefined: the wrapped result is stored and reported.
- `err_code` = 3 in both cases.

Decomposition:
- Package sm_pkg holds:
  - Opcode localparams OP_PUSH..OP_END.
  - Error localparams ERR_OK, ERR_UNDER, ERR_OVER, ERR_ARITH.
  - State encoding S_RUN, S_DONE.
- One combinational sub-module, sm_alu: inputs a, b, op; outputs result[DATA_W-1:0] and ovf. It contains the SM_SAT_EN logic.
- Stack register array, stack pointer and FSM stay in sm_param.

Test Plan (DATA_W=20, IMM_W=10, DEPTH=8):
- PUSH 3, PUSH 5, SUB, MUL -> reports 3/0, 5/0, -2/0, then MUL with 1 entry -> 0/err1; stack still holds -2.
- Nine PUSH 1 -> first eight report 1/0; ninth reports 0/err2; then POP -> 1/0.
- PUSH 511, DUP, MUL, DUP, MUL:
  - Reports 511/0, 511/0, 261121/0, 261121/0.
  - Final MUL overflows: wrapped low 20 bits, err3.
  - With SM_SAT_EN: 524287, err3.
- PUSH -512, PUSH 7, SWAP, SUB -> -512/0, 7/0, -512/0, 519/0; SWAP on the single remaining entry -> 0/err1.
- PUSH 4, END -> `d_valid` with 4/0; `fin` = 1 next cycle and stays; `pc` frozen at 2; `d_valid` stays 0.
- Assert `rst_n` low mid-program after 3 pushes -> `pc` = 0, outputs 0 immediately; after release, POP -> 0/err1.
